// File: rtl/data_memory_be.sv
// Word-addressed data memory with per-byte store enables, range checking and a post-reset zeroing pass.
// Latency: load data, dvalid and derr are registered and appear 1 cycle after the request is accepted.
// Backpressure: req_ready stays low for DEPTH cycles after reset while the memory clears, then stays high.
module data_memory_be #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    write,
    input  logic [DATA_WIDTH/8-1:0] byte_en,
    input  logic [ADDR_WIDTH-1:0]   daddress,
    input  logic [DATA_WIDTH-1:0]   din,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    dvalid,
    output logic                    derr
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        cnt_q, cnt_d;
    logic                    req_ready_q, req_ready_d;
    logic [DATA_WIDTH-1:0]   dout_q, dout_d;
    logic                    dvalid_q, dvalid_d;
    logic                    derr_q, derr_d;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic                    mem_we;
    logic [IDX_W-1:0]        mem_waddr;
    logic [NB-1:0]           mem_wbe;
    logic [DATA_WIDTH-1:0]   mem_wdata;

    logic                    in_range;
    logic [IDX_W-1:0]        req_idx;
    logic                    accept;

    // Compare on the full address width so large addresses never alias into the array.
    assign in_range = ({1'b0, daddress} < DEPTH_EXT);
    assign req_idx  = daddress[IDX_W-1:0];
    assign accept   = req_valid && req_ready_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_ready_d = req_ready_q;
        dout_d      = dout_q;
        dvalid_d    = 1'b0;
        derr_d      = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = req_idx;
        mem_wbe     = byte_en;
        mem_wdata   = din;

        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wbe   = '1;
                mem_wdata = '0;
                cnt_d     = cnt_q + IDX_W'(1);
                if (cnt_q == LAST_IDX) begin
                    state_d     = ST_RUN;
                    req_ready_d = 1'b1;
                    cnt_d       = '0;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (!in_range) begin
                        derr_d   = 1'b1;
                        dout_d   = '0;
                        dvalid_d = !write;
                    end else if (write) begin
                        mem_we = 1'b1;
                        dout_d = '0;
                    end else begin
                        dout_d   = mem_q[req_idx];
                        dvalid_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_CLEAR;
        endcase

        // A store coinciding with reset is dropped.
        if (reset) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_CLEAR;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            dout_q      <= '0;
            dvalid_q    <= 1'b0;
            derr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            dout_q      <= dout_d;
            dvalid_q    <= dvalid_d;
            derr_q      <= derr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_wbe[i]) begin
                    mem_q[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = req_ready_q;
    assign dout      = dout_q;
    assign dvalid    = dvalid_q;
    assign derr      = derr_q;

endmodule
